// File: rtl/fpu_issue_sched_if.sv
// Bundle of request, strobe, divider and writeback signals between decode and the FPU scheduler.
// Ports (scheduler view, slave modport):
//   in : req_valid, req_funct7[6:0], req_funct3[2:0], req_tag[TAG_W-1:0], flush, div_done
//   out: req_ready, iss_add, iss_mul, iss_div, iss_misc, wb_valid, wb_tag[TAG_W-1:0], wb_sel[1:0], busy
interface fpu_issue_sched_if #(
    parameter int unsigned TAG_W = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [6:0]       req_funct7;
    logic [2:0]       req_funct3;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             iss_add;
    logic             iss_mul;
    logic             iss_div;
    logic             iss_misc;
    logic             div_done;
    logic             wb_valid;
    logic [TAG_W-1:0] wb_tag;
    logic [1:0]       wb_sel;
    logic             busy;

    // Decode side drives requests and sees strobes/writeback.
    modport master (
        output req_valid, req_funct7, req_funct3, req_tag, flush, div_done,
        input  req_ready, iss_add, iss_mul, iss_div, iss_misc,
        input  wb_valid, wb_tag, wb_sel, busy
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_funct7, req_funct3, req_tag, flush, div_done,
        output req_ready, iss_add, iss_mul, iss_div, iss_misc,
        output wb_valid, wb_tag, wb_sel, busy
    );
endinterface

// File: rtl/fpu_issue_sched.sv
// Issue scheduler sharing one FPU writeback port between ADD, MUL, DIV and MISC units.
// Accepts one op per cycle, fires a one-hot unit strobe on accept, and reserves the
// writeback slot so at most one result retires per cycle.
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   bus (slave)   request handshake, unit strobes, div_done, writeback tag/select, busy
//   perf_issued   (FPU_SCHED_PERF_EN only) saturating count of accepted ops
//   perf_stall    (FPU_SCHED_PERF_EN only) saturating count of req_valid & !req_ready cycles
// Optional feature macro: FPU_SCHED_PERF_EN.
// req_ready and iss_* are combinational; wb_* and busy are registered.
module fpu_issue_sched #(
    parameter int unsigned TAG_W    = 4,
    parameter int unsigned LAT_MISC = 1,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_ADD  = 3,
    parameter int unsigned MAX_LAT  = 8
) (
    input  logic                clk,
    input  logic                rst,
    fpu_issue_sched_if.slave    bus
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0]         perf_issued,
    output logic [31:0]         perf_stall
`endif
);

    localparam logic [1:0] SEL_MISC = 2'd0;
    localparam logic [1:0] SEL_ADD  = 2'd1;
    localparam logic [1:0] SEL_MUL  = 2'd2;
    localparam logic [1:0] SEL_DIV  = 2'd3;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       sel;
    } slot_t;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_HOLD = 2'd2
    } div_state_t;

    // slots[k]: writeback owned k cycles from now; slots[0] is the live writeback.
    slot_t            slots  [0:MAX_LAT];
    slot_t            slot_n [0:MAX_LAT];
    div_state_t       div_state;
    logic [TAG_W-1:0] div_tag;
    logic             busy_q;

    logic cls_add, cls_mul, cls_div, cls_misc;
    logic ready, accept;
    logic iss_add, iss_mul, iss_div, iss_misc;
    logic div_retire;
    logic div_active_n;
    logic any_slot_n;

    logic unused_funct3;
    assign unused_funct3 = ^bus.req_funct3;

    // Class decode and per-class readiness.
    always_comb begin
        cls_add  = 1'b0;
        cls_mul  = 1'b0;
        cls_div  = 1'b0;
        cls_misc = 1'b0;
        ready    = 1'b0;
        case (bus.req_funct7)
            7'h00, 7'h04: cls_add  = 1'b1;
            7'h08:        cls_mul  = 1'b1;
            7'h0C:        cls_div  = 1'b1;
            default:      cls_misc = 1'b1;
        endcase
        // A waiting DIV owns the next free slot, so pipelined issue halts in HOLD.
        if (!rst && !bus.flush) begin
            ready = (cls_add  && !slots[LAT_ADD].valid  && (div_state != DIV_HOLD)) ||
                    (cls_mul  && !slots[LAT_MUL].valid  && (div_state != DIV_HOLD)) ||
                    (cls_misc && !slots[LAT_MISC].valid && (div_state != DIV_HOLD)) ||
                    (cls_div  && (div_state == DIV_IDLE));
        end
    end

    assign accept   = bus.req_valid & ready;
    assign iss_add  = accept & cls_add;
    assign iss_mul  = accept & cls_mul;
    assign iss_div  = accept & cls_div;
    assign iss_misc = accept & cls_misc;

    // DIV takes the first cycle whose writeback is not already reserved.
    assign div_retire = (div_state == DIV_HOLD) && !slots[1].valid && !bus.flush;

    // Ring next state: shift down, insert new reservations, flush wipes everything.
    always_comb begin
        for (int k = 0; k < int'(MAX_LAT); k++) begin
            slot_n[k] = slots[k + 1];
        end
        slot_n[MAX_LAT] = '0;
        if (iss_add)  slot_n[LAT_ADD - 1]  = '{valid: 1'b1, tag: bus.req_tag, sel: SEL_ADD};
        if (iss_mul)  slot_n[LAT_MUL - 1]  = '{valid: 1'b1, tag: bus.req_tag, sel: SEL_MUL};
        if (iss_misc) slot_n[LAT_MISC - 1] = '{valid: 1'b1, tag: bus.req_tag, sel: SEL_MISC};
        if (div_retire) slot_n[0] = '{valid: 1'b1, tag: div_tag, sel: SEL_DIV};
        if (bus.flush) begin
            for (int k = 0; k <= int'(MAX_LAT); k++) begin
                slot_n[k] = '0;
            end
        end
    end

    // Whether the DIV FSM will be out of IDLE next cycle, for the registered busy.
    always_comb begin
        div_active_n = 1'b0;
        any_slot_n   = 1'b0;
        if (!bus.flush) begin
            case (div_state)
                DIV_IDLE: div_active_n = iss_div;
                DIV_RUN:  div_active_n = 1'b1;
                DIV_HOLD: div_active_n = !div_retire;
                default:  div_active_n = 1'b0;
            endcase
        end
        for (int k = 0; k <= int'(MAX_LAT); k++) begin
            any_slot_n = any_slot_n | slot_n[k].valid;
        end
    end

    // Reservation ring and busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= int'(MAX_LAT); k++) begin
                slots[k] <= '0;
            end
            busy_q <= 1'b0;
        end else begin
            for (int k = 0; k <= int'(MAX_LAT); k++) begin
                slots[k] <= slot_n[k];
            end
            busy_q <= any_slot_n | div_active_n;
        end
    end

    // DIV FSM; HOLD is left on the edge that loads the DIV result into the writeback.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_state <= DIV_IDLE;
            div_tag   <= '0;
        end else if (bus.flush) begin
            div_state <= DIV_IDLE;
        end else begin
            case (div_state)
                DIV_IDLE: if (iss_div) begin
                    div_tag   <= bus.req_tag;
                    div_state <= DIV_RUN;
                end
                DIV_RUN:  if (bus.div_done) div_state <= DIV_HOLD;
                DIV_HOLD: if (div_retire)   div_state <= DIV_IDLE;
                default:  div_state <= DIV_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready;
    assign bus.iss_add   = iss_add;
    assign bus.iss_mul   = iss_mul;
    assign bus.iss_div   = iss_div;
    assign bus.iss_misc  = iss_misc;
    assign bus.wb_valid  = slots[0].valid;
    assign bus.wb_tag    = slots[0].tag;
    assign bus.wb_sel    = slots[0].sel;
    assign bus.busy      = busy_q;

`ifdef FPU_SCHED_PERF_EN
    // Saturating counters; flush does not clear them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && (perf_issued != 32'hFFFF_FFFF))
                perf_issued <= perf_issued + 32'd1;
            if (bus.req_valid && !ready && (perf_stall != 32'hFFFF_FFFF))
                perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fpu_issue_sched.sv
// Bench for fpu_issue_sched: calendar-based writeback model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_fpu_issue_sched;

    localparam int unsigned TAG_W   = 4;
    localparam int          MAX_LAT = 8;
    localparam int          NCYC    = 512;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_issue_sched_if #(.TAG_W(TAG_W)) bus ();

`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    fpu_issue_sched #(
        .TAG_W(TAG_W), .LAT_MISC(1), .LAT_MUL(2), .LAT_ADD(3), .MAX_LAT(MAX_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef FPU_SCHED_PERF_EN
        ,
        .perf_issued(perf_issued),
        .perf_stall(perf_stall)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Model: absolute-cycle writeback calendar plus DIV phase (0 idle, 1 running, 2 waiting for a slot).
    int         cyc = 0;
    bit         rv [NCYC];
    logic [3:0] rt [NCYC];
    logic [1:0] rs [NCYC];
    int         dphase = 0;
    logic [3:0] dtag   = '0;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] m_issued = '0;
    logic [31:0] m_stall  = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Class code doubles as the writeback select: 0 MISC, 1 ADD, 2 MUL, 3 DIV.
    function automatic int cls_of(input logic [6:0] f);
        if (f == 7'h00 || f == 7'h04) return 1;
        if (f == 7'h08) return 2;
        if (f == 7'h0C) return 3;
        return 0;
    endfunction

    function automatic int lat_of(input int c);
        if (c == 1) return 3;
        if (c == 2) return 2;
        return 1;
    endfunction

    function automatic bit m_ready();
        int c;
        c = cls_of(bus.req_funct7);
        if (rst || bus.flush) return 1'b0;
        if (c == 3) return dphase == 0;
        if (dphase == 2) return 1'b0;
        return !rv[cyc + lat_of(c)];
    endfunction

    task automatic clear_cal(input int from, input int to);
        for (int j = from; j <= to && j < NCYC; j++) rv[j] = 1'b0;
    endtask

    int m_c, m_old;
    bit m_acc, m_rdy;
    always @(posedge clk) begin
        if (!rst) begin
            m_c   = cls_of(bus.req_funct7);
            m_rdy = m_ready();
            m_acc = bus.req_valid && m_rdy;
`ifdef FPU_SCHED_PERF_EN
            if (m_acc && m_issued != 32'hFFFF_FFFF) m_issued++;
            if (bus.req_valid && !m_rdy && m_stall != 32'hFFFF_FFFF) m_stall++;
`endif
            if (bus.flush) begin
                clear_cal(cyc + 1, cyc + MAX_LAT + 1);
                dphase = 0;
            end else begin
                m_old = dphase;
                if (m_acc && m_c == 3) begin
                    dphase = 1;
                    dtag   = bus.req_tag;
                end else if (m_acc) begin
                    rv[cyc + lat_of(m_c)] = 1'b1;
                    rt[cyc + lat_of(m_c)] = bus.req_tag;
                    rs[cyc + lat_of(m_c)] = 2'(m_c);
                end
                if (m_old == 1 && bus.div_done) dphase = 2;
                if (m_old == 2 && !rv[cyc + 1]) begin
                    rv[cyc + 1] = 1'b1;
                    rt[cyc + 1] = dtag;
                    rs[cyc + 1] = 2'd3;
                    dphase = 0;
                end
            end
        end
        cyc++;
    end

    always @(posedge rst) begin
        clear_cal(cyc, cyc + MAX_LAT + 1);
        dphase = 0;
    end

    // Per-cycle comparison against the model.
    logic [3:0] e_iss;
    bit         e_rdy, e_busy;
    int         e_c;
    always @(negedge clk) begin
        e_c   = cls_of(bus.req_funct7);
        e_rdy = m_ready();
        e_iss = (bus.req_valid && e_rdy) ?
                {e_c == 1, e_c == 2, e_c == 3, e_c == 0} : 4'b0000;
        e_busy = (dphase != 0);
        for (int j = cyc; j <= cyc + MAX_LAT && j < NCYC; j++) e_busy = e_busy | rv[j];
        chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
        chk("iss_onehot", 32'({bus.iss_add, bus.iss_mul, bus.iss_div, bus.iss_misc}), 32'(e_iss));
        chk("wb_valid", 32'(bus.wb_valid), 32'(rv[cyc]));
        if (rv[cyc]) begin
            chk("wb_tag", 32'(bus.wb_tag), 32'(rt[cyc]));
            chk("wb_sel", 32'(bus.wb_sel), 32'(rs[cyc]));
        end
        chk("busy", 32'(bus.busy), 32'(e_busy));
`ifdef FPU_SCHED_PERF_EN
        chk("perf_issued", perf_issued, m_issued);
        chk("perf_stall", perf_stall, m_stall);
`endif
    end

    // Drive one cycle of inputs, then return just after that cycle's falling edge.
    task automatic tick(input logic v, input logic [6:0] f7, input logic [3:0] tg,
                        input logic fl, input logic dd);
        @(posedge clk);
        #1;
        bus.req_valid  = v;
        bus.req_funct7 = f7;
        bus.req_funct3 = 3'($urandom);
        bus.req_tag    = tg;
        bus.flush      = fl;
        bus.div_done   = dd;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b0);
    endtask

`ifdef FPU_SCHED_PERF_EN
    logic [31:0] p_iss0, p_stl0;
`endif

    initial begin
        for (int j = 0; j < NCYC; j++) begin
            rv[j] = 1'b0;
            rt[j] = '0;
            rs[j] = '0;
        end
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_funct7 = 7'h00;
        bus.req_funct3 = 3'd0;
        bus.req_tag    = 4'd0;
        bus.flush      = 1'b0;
        bus.div_done   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        // MISC tag 3: strobe now, writeback next cycle with sel 0.
        tick(1'b1, 7'h10, 4'd3, 1'b0, 1'b0);
        chk("misc_ready", 32'(bus.req_ready), 32'd1);
        chk("misc_iss", 32'(bus.iss_misc), 32'd1);
        idle(1);
        chk("misc_wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("misc_wb_tag", 32'(bus.wb_tag), 32'd3);
        chk("misc_wb_sel", 32'(bus.wb_sel), 32'd0);
        idle(2);

        // ADD tag 1 at t0 blocks a MISC at t2; MISC accepted at t3.
        tick(1'b1, 7'h00, 4'd1, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 7'h10, 4'd2, 1'b0, 1'b0);
        chk("collide_ready", 32'(bus.req_ready), 32'd0);
        tick(1'b1, 7'h10, 4'd2, 1'b0, 1'b0);
        chk("collide_ready_t3", 32'(bus.req_ready), 32'd1);
        chk("add_wb_tag", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd1, 2'd1}));
        idle(1);
        chk("misc2_wb", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd2, 2'd0}));
        idle(3);

        // ADD (funct7 04) then MUL one cycle later both target the same slot.
        tick(1'b1, 7'h04, 4'd4, 1'b0, 1'b0);
        tick(1'b1, 7'h08, 4'd6, 1'b0, 1'b0);
        chk("mul_stall", 32'(bus.req_ready), 32'd0);
        tick(1'b1, 7'h08, 4'd6, 1'b0, 1'b0);
        chk("mul_retry", 32'(bus.req_ready), 32'd1);
        idle(5);

        // DIV tag 5 with MISC in RUN, MUL at t5, div_done at t6.
        tick(1'b1, 7'h0C, 4'd5, 1'b0, 1'b0);
        chk("div_iss", 32'(bus.iss_div), 32'd1);
        idle(1);
        tick(1'b1, 7'h0C, 4'd7, 1'b0, 1'b0);
        chk("div2_held_run", 32'(bus.req_ready), 32'd0);
        tick(1'b1, 7'h7F, 4'd8, 1'b0, 1'b0);
        chk("misc_in_run", 32'(bus.req_ready), 32'd1);
        idle(1);
        tick(1'b1, 7'h08, 4'd9, 1'b0, 1'b0);
        chk("mul_in_run", 32'(bus.iss_mul), 32'd1);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        tick(1'b1, 7'h0C, 4'd7, 1'b0, 1'b0);
        chk("div2_held_hold", 32'(bus.req_ready), 32'd0);
        chk("mul_wb_t7", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd9, 2'd2}));
        tick(1'b1, 7'h0C, 4'd7, 1'b0, 1'b0);
        chk("div_wb_t8", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd5, 2'd3}));
        chk("div2_accept", 32'(bus.iss_div), 32'd1);
        idle(2);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        idle(4);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        idle(2);

        // DIV in HOLD waits behind an ADD writeback; pipelined issue stalls meanwhile.
        tick(1'b1, 7'h0C, 4'd10, 1'b0, 1'b0);
        tick(1'b1, 7'h00, 4'd11, 1'b0, 1'b0);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        tick(1'b1, 7'h10, 4'd12, 1'b0, 1'b0);
        chk("hold_stall", 32'(bus.req_ready), 32'd0);
        tick(1'b1, 7'h10, 4'd12, 1'b0, 1'b0);
        chk("hold_add_wb", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd11, 2'd1}));
        tick(1'b1, 7'h10, 4'd12, 1'b0, 1'b0);
        chk("hold_div_wb", 32'({bus.wb_valid, bus.wb_tag, bus.wb_sel}), 32'({1'b1, 4'd10, 2'd3}));
        chk("after_hold_ready", 32'(bus.req_ready), 32'd1);
        idle(3);

        // Flush: ADD at t0, MUL at t1, flush at t2.
        tick(1'b1, 7'h00, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 7'h08, 4'd2, 1'b0, 1'b0);
        tick(1'b1, 7'h08, 4'd2, 1'b1, 1'b0);
        chk("flush_ready", 32'(bus.req_ready), 32'd0);
        idle(1);
        chk("flush_busy_t3", 32'(bus.busy), 32'd0);
        chk("flush_wb_t3", 32'(bus.wb_valid), 32'd0);
        idle(1);
        chk("flush_wb_t4", 32'(bus.wb_valid), 32'd0);
        idle(1);
        chk("flush_wb_t5", 32'(bus.wb_valid), 32'd0);
        idle(1);

        // Flush while DIV runs; a late div_done is ignored.
        tick(1'b1, 7'h0C, 4'd13, 1'b0, 1'b0);
        idle(1);
        tick(1'b1, 7'h0C, 4'd14, 1'b1, 1'b0);
        chk("flush_div_iss", 32'(bus.iss_div), 32'd0);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        idle(3);
        chk("late_done_wb", 32'(bus.wb_valid), 32'd0);
        chk("late_done_busy", 32'(bus.busy), 32'd0);
        tick(1'b1, 7'h0C, 4'd15, 1'b0, 1'b0);
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        idle(3);

        // Reset with DIV running and two slots reserved.
        tick(1'b1, 7'h0C, 4'd1, 1'b0, 1'b0);
        tick(1'b1, 7'h00, 4'd2, 1'b0, 1'b0);
        tick(1'b1, 7'h10, 4'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        chk("rstmid_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rstmid_busy", 32'(bus.busy), 32'd0);
        chk("rstmid_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        tick(1'b0, 7'h00, 4'd0, 1'b0, 1'b1);
        idle(2);
        chk("rstmid_no_div_wb", 32'(bus.wb_valid), 32'd0);
        idle(2);

        // Ten request cycles: four accepted ADDs, then six refused under flush.
`ifdef FPU_SCHED_PERF_EN
        p_iss0 = perf_issued;
        p_stl0 = perf_stall;
`endif
        for (int i = 0; i < 4; i++) tick(1'b1, 7'h00, 4'(i + 4), 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b1, 7'h10, 4'd0, 1'b1, 1'b0);
        idle(1);
`ifdef FPU_SCHED_PERF_EN
        chk("perf_issued_delta", perf_issued - p_iss0, 32'd4);
        chk("perf_stall_delta", perf_stall - p_stl0, 32'd6);
`endif
        idle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
